// File: rtl/nibble_serial_sub_pkg.sv
// nibble_serial_sub shared definitions:
// FSM encodings and nibble counter sizing.
package nibble_serial_sub_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Counter width for nib nibbles, never below one bit.
    function automatic int nib_bits(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_sub_nibble_sub4.sv
// nibble_sub4: combinational 4-bit ripple-borrow
// subtractor built from full subtractors.
module nibble_sub4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       kin,
    output logic [3:0] d,
    output logic       kout
);

    logic [4:0] k;

    assign k[0] = kin;

    for (genvar i = 0; i < 4; i++) begin : g_fs
        assign d[i]   = a[i] ^ b[i] ^ k[i];
        assign k[i+1] = (~a[i] & b[i])
                      | (~(a[i] ^ b[i]) & k[i]);
    end

    assign kout = k[4];

endmodule

// File: rtl/nibble_serial_sub.sv
// nibble_serial_sub: WIDTH-bit A - B - Bin computed
// one nibble per clock through a 4-bit borrow stage.
module nibble_serial_sub
    import nibble_serial_sub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             zero
);

    localparam int NIB = WIDTH / 4;
    localparam int NB  = nib_bits(NIB);
    localparam logic [NB-1:0] LAST = NB'(NIB - 1);

    logic [1:0]       state;
    logic [NB-1:0]    cnt;
    logic             brw;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_nxt;
    logic [3:0]       dn;
    logic             ko;
    logic             last;

    nibble_sub4 u_sub (
        .a    (sa[3:0]),
        .b    (sb[3:0]),
        .kin  (brw),
        .d    (dn),
        .kout (ko)
    );

    // New nibble enters at the top; after NIB shifts
    // the first nibble has reached the bottom.
    assign res_nxt = WIDTH'({dn, res} >> 4);
    assign last    = (cnt == LAST);

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // Sequencer: IDLE -> RUN for NIB cycles -> DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        cnt   <= '0;
                    end
                end
                S_RUN: begin
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Operand capture and per-nibble shifting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa  <= '0;
            sb  <= '0;
            brw <= 1'b0;
            res <= '0;
        end else if (state == S_IDLE) begin
            if (start) begin
                sa  <= a;
                sb  <= b;
                brw <= bin;
            end
        end else if (state == S_RUN) begin
            sa  <= sa >> 4;
            sb  <= sb >> 4;
            brw <= ko;
            res <= res_nxt;
        end
    end

    // Visible result, touched only on the final nibble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d    <= '0;
            bout <= 1'b0;
            zero <= 1'b1;
        end else if (state == S_RUN && last) begin
            d    <= res_nxt;
            bout <= ko;
            zero <= ~|res_nxt;
        end
    end

endmodule

// File: tb/tb_nibble_serial_sub.sv
// tb_nibble_serial_sub: scoreboard bench for
// WIDTH=16, 8 and 4 instances.
module tb_nibble_serial_sub;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        start16 = 0;
    logic [15:0] a16 = 0;
    logic [15:0] b16 = 0;
    logic        bin16 = 0;
    logic        busy16;
    logic        done16;
    logic [15:0] d16;
    logic        bout16;
    logic        zero16;

    logic        start8 = 0;
    logic [7:0]  a8 = 0;
    logic [7:0]  b8 = 0;
    logic        bin8 = 0;
    logic        busy8;
    logic        done8;
    logic [7:0]  d8;
    logic        bout8;
    logic        zero8;

    logic        start4 = 0;
    logic [3:0]  a4 = 0;
    logic [3:0]  b4 = 0;
    logic        bin4 = 0;
    logic        busy4;
    logic        done4;
    logic [3:0]  d4;
    logic        bout4;
    logic        zero4;

    nibble_serial_sub #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .start(start16),
        .a(a16), .b(b16), .bin(bin16),
        .busy(busy16), .done(done16), .d(d16),
        .bout(bout16), .zero(zero16)
    );

    nibble_serial_sub #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8),
        .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .d(d8),
        .bout(bout8), .zero(zero8)
    );

    nibble_serial_sub #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .start(start4),
        .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .d(d4),
        .bout(bout4), .zero(zero4)
    );

    // expected entries are {zero, bout, d}
    logic [17:0] q16[$];
    logic [9:0]  q8[$];
    logic [5:0]  q4[$];

    logic [17:0] hold16 = {1'b1, 1'b0, 16'h0000};
    int dones16 = 0;
    int dones8  = 0;
    int dones4  = 0;

    function automatic logic [17:0] m16(
        input logic [15:0] a, input logic [15:0] b,
        input logic bi);
        logic [16:0] r;
        r = {1'b0, a} - {1'b0, b} - {16'b0, bi};
        return {r[15:0] == 16'h0, r[16], r[15:0]};
    endfunction

    function automatic logic [9:0] m8(
        input logic [7:0] a, input logic [7:0] b,
        input logic bi);
        logic [8:0] r;
        r = {1'b0, a} - {1'b0, b} - {8'b0, bi};
        return {r[7:0] == 8'h0, r[8], r[7:0]};
    endfunction

    function automatic logic [5:0] m4(
        input logic [3:0] a, input logic [3:0] b,
        input logic bi);
        logic [4:0] r;
        r = {1'b0, a} - {1'b0, b} - {4'b0, bi};
        return {r[3:0] == 4'h0, r[4], r[3:0]};
    endfunction

    // u16 monitor: result on done, stability otherwise
    always @(negedge clk) begin
        logic [17:0] e;
        if (done16) begin
            checks++;
            if (q16.size() == 0) begin
                errors++;
                $display("FAIL done16_unexpected got %h want none",
                         {zero16, bout16, d16});
            end else begin
                e = q16.pop_front();
                dones16++;
                if ({zero16, bout16, d16} !== e) begin
                    errors++;
                    $display("FAIL res16 got %h want %h",
                             {zero16, bout16, d16}, e);
                end
                hold16 = e;
            end
        end else begin
            checks++;
            if ({zero16, bout16, d16} !== hold16) begin
                errors++;
                $display("FAIL hold16 got %h want %h",
                         {zero16, bout16, d16}, hold16);
            end
        end
    end

    // u8 monitor
    always @(negedge clk) begin
        logic [9:0] e;
        if (done8) begin
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL done8_unexpected got %h want none",
                         {zero8, bout8, d8});
            end else begin
                e = q8.pop_front();
                dones8++;
                if ({zero8, bout8, d8} !== e) begin
                    errors++;
                    $display("FAIL res8 got %h want %h",
                             {zero8, bout8, d8}, e);
                end
            end
        end
    end

    // u4 monitor
    always @(negedge clk) begin
        logic [5:0] e;
        if (done4) begin
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL done4_unexpected got %h want none",
                         {zero4, bout4, d4});
            end else begin
                e = q4.pop_front();
                dones4++;
                if ({zero4, bout4, d4} !== e) begin
                    errors++;
                    $display("FAIL res4 got %h want %h",
                             {zero4, bout4, d4}, e);
                end
            end
        end
    end

    task automatic chk(input string name,
                       input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // one op on u16; called from an IDLE negedge
    task automatic do16(input logic [15:0] a,
                        input logic [15:0] b,
                        input logic bi,
                        input logic [17:0] e);
        int n;
        q16.push_back(e);
        a16 = a;
        b16 = b;
        bin16 = bi;
        start16 = 1'b1;
        n = 0;
        @(negedge clk);
        n++;
        start16 = 1'b0;
        a16 = ~a;
        b16 = ~b;
        bin16 = ~bi;
        chk("busy16_run", 32'(busy16), 32'd1);
        while (!done16 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("lat16", n, 32'd5);
        @(negedge clk);
        chk("idle16", {30'b0, busy16, done16}, 32'd0);
    endtask

    task automatic do8(input logic [7:0] a,
                       input logic [7:0] b,
                       input logic bi);
        int n;
        q8.push_back(m8(a, b, bi));
        a8 = a;
        b8 = b;
        bin8 = bi;
        start8 = 1'b1;
        n = 0;
        @(negedge clk);
        n++;
        start8 = 1'b0;
        a8 = ~a;
        while (!done8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("lat8", n, 32'd3);
        @(negedge clk);
    endtask

    task automatic do4(input logic [3:0] a,
                       input logic [3:0] b,
                       input logic bi);
        int n;
        q4.push_back(m4(a, b, bi));
        a4 = a;
        b4 = b;
        bin4 = bi;
        start4 = 1'b1;
        n = 0;
        @(negedge clk);
        n++;
        start4 = 1'b0;
        a4 = ~a;
        while (!done4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("lat4", n, 32'd2);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy16), 32'd0);
        chk("rst_done", 32'(done16), 32'd0);
        chk("rst_d", 32'(d16), 32'd0);
        chk("rst_bout", 32'(bout16), 32'd0);
        chk("rst_zero", 32'(zero16), 32'd1);
        #2 rst = 1'b0;
        @(negedge clk);

        do16(16'h1234, 16'h0234, 1'b0,
             {1'b0, 1'b0, 16'h1000});
        do16(16'h1000, 16'h0001, 1'b0,
             {1'b0, 1'b0, 16'h0FFF});
        do16(16'h0000, 16'h0001, 1'b0,
             {1'b0, 1'b1, 16'hFFFF});
        do16(16'h8000, 16'h7FFF, 1'b1,
             {1'b1, 1'b0, 16'h0000});
        do16(16'h0000, 16'hFFFF, 1'b1,
             {1'b1, 1'b1, 16'h0000});
        do16(16'hFFFF, 16'h0000, 1'b1,
             {1'b0, 1'b0, 16'hFFFE});

        // start held high, operands change every cycle;
        // only those present in an IDLE cycle are taken
        base = dones16;
        start16 = 1'b1;
        for (int k = 0; k < 18; k++) begin
            a16 = 16'h0055 + 16'(k) * 16'h0100;
            b16 = 16'(k) * 16'h0011 + 16'h0040;
            bin16 = k[0];
            if (k % 6 == 0) begin
                q16.push_back(m16(a16, b16, bin16));
            end
            @(negedge clk);
        end
        start16 = 1'b0;
        repeat (3) @(negedge clk);
        chk("stream16_dones", dones16 - base, 32'd3);

        // reset during the second RUN cycle
        a16 = 16'hABCD;
        b16 = 16'h1234;
        bin16 = 1'b0;
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        hold16 = {1'b1, 1'b0, 16'h0000};
        chk("mid_busy", 32'(busy16), 32'd0);
        chk("mid_d", 32'(d16), 32'd0);
        chk("mid_zero", 32'(zero16), 32'd1);
        chk("mid_bout", 32'(bout16), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("post_busy", 32'(busy16), 32'd0);
        do16(16'h5A5A, 16'h1234, 1'b0,
             {1'b0, 1'b0, 16'h4826});

        for (int i = 0; i < 1000; i++) begin
            do8(8'($urandom), 8'($urandom),
                1'($urandom));
        end
        for (int i = 0; i < 1000; i++) begin
            do4(4'($urandom), 4'($urandom),
                1'($urandom));
        end
        do8(8'h00, 8'hFF, 1'b1);
        do4(4'h0, 4'hF, 1'b1);

        repeat (2) @(negedge clk);
        chk("q16_empty", q16.size(), 32'd0);
        chk("q8_empty", q8.size(), 32'd0);
        chk("q4_empty", q4.size(), 32'd0);
        chk("dones8", dones8, 32'd1001);
        chk("dones4", dones4, 32'd1001);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
